logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 1..64).
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  upstream presents a, b, op.
REQ-006 Port in_ready  output  1  block accepts input this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port op  input  3  operation select.
REQ-010 Port out_valid  output  1  y, zero, parity valid.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port y  output  WIDTH  bitwise result.
REQ-013 Port zero  output  1  high when y == 0.
REQ-014 Port parity  output  1  XOR-reduction of y.
REQ-015 Port op_cnt  output  CNT_W  completed-output counter.

Function
REQ-016 op encoding SHALL be: 000 AND, 001 OR, 010 NAND, 011 NOT (~a, b ignored), 100 NOR, 101 XOR, 110 XNOR, 111 PASS (y = a).
REQ-017 All operations SHALL be bitwise across WIDTH bits, with no carries and no width extension.
REQ-018 Pipeline SHALL have two register stages: S1 captures a/b/op on input handshake, S2 holds computed y/zero/parity.
REQ-019 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-020 Latency SHALL be exactly 2 cycles from input handshake to out_valid high when no stall occurs.
REQ-021 Throughput SHALL be 1 operation/cycle when out_ready is held high.
REQ-022 S2 SHALL load from S1 when S1 is valid and (S2 empty or out_ready).
REQ-023 in_ready SHALL be high when S1 is empty or S1 advances this cycle (combinational from out_ready); max occupancy 2 operations.
REQ-024 While out_valid && !out_ready: y/zero/parity SHALL hold stable; in_ready SHALL drop once S1 is also full.
REQ-025 Simultaneous output handshake and input handshake with both stages full SHALL shift S1->S2 and load S1 in the same cycle, with no loss or duplication.
REQ-026 Results SHALL emerge in acceptance order.
REQ-027 in_valid without in_ready SHALL NOT change internal state; a/b/op are sampled only on handshake.

Reset
REQ-028 On rst_n low, asynchronously: out_valid=0, S1 valid=0, y=0, zero=0, parity=0, op_cnt=0.
REQ-029 in_ready SHALL be 1 while in reset.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; no output appears for them after release.
REQ-031 First input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro LOGIC_UNIT_STAT_CNT_EN defined: op_cnt SHALL increment by 1 on each output handshake and saturate at 2^CNT_W-1.
REQ-033 Macro LOGIC_UNIT_STAT_CNT_EN undefined: op_cnt port SHALL still exist, tied to constant 0, with no counter flops.

Verification
REQ-034 Reset, then a=8'hF0, b=8'h3C, op=000 with out_ready=1 -> 2 cycles later y=8'h30, zero=0, parity=0.
REQ-035 Back-to-back ops 000..111 with a=8'hAA, b=8'h55, out_ready=1 -> y sequence 00, FF, FF, 55, 00, FF, 00, AA on consecutive cycles; zero=1 on the AND/NOR/XNOR results.
REQ-036 out_ready=0 for 5 cycles while in_valid=1 -> in_ready low after 2 accepts, y stable; release -> both results emerge in order, next input accepted the same cycle.
REQ-037 rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately and stays 0 after release until a new input is accepted.
REQ-038 With LOGIC_UNIT_STAT_CNT_EN defined and CNT_W=4: 20 output handshakes -> op_cnt=15 (saturated); without the macro, op_cnt=0 throughout.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with zero/parity flags.
// Optional completed-op counter enabled by defining LOGIC_UNIT_STAT_CNT_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;

  logic [WIDTH-1:0] res;
  logic             in_fire;
  logic             s2_load;

  // S1 moves into S2 when S2 is empty or being drained this cycle
  assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
  assign in_ready = !s1_vld_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  // bitwise operation on the S1 operands
  always_comb begin
    res = '0;
    unique case (s1_op_q)
      OP_AND:  res = s1_a_q & s1_b_q;
      OP_OR:   res = s1_a_q | s1_b_q;
      OP_NAND: res = ~(s1_a_q & s1_b_q);
      OP_NOT:  res = ~s1_a_q;
      OP_NOR:  res = ~(s1_a_q | s1_b_q);
      OP_XOR:  res = s1_a_q ^ s1_b_q;
      OP_XNOR: res = ~(s1_a_q ^ s1_b_q);
      OP_PASS: res = s1_a_q;
    endcase
  end

  // next-state for both stages; operands sampled only on handshake
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_op_d  = s1_op_q;
    s2_vld_d = s2_vld_q;
    y_d      = y_q;
    zero_d   = zero_q;
    par_d    = par_q;
    if (in_fire) begin
      s1_vld_d = 1'b1;
      s1_a_d   = a;
      s1_b_d   = b;
      s1_op_d  = op;
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end
    if (s2_load) begin
      s2_vld_d = 1'b1;
      y_d      = res;
      zero_d   = (res == '0);
      par_d    = ^res;
    end else if (out_ready) begin
      s2_vld_d = 1'b0;
    end
  end

  // pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_op_q  <= '0;
      s2_vld_q <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_op_q  <= s1_op_d;
      s2_vld_q <= s2_vld_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      par_q    <= par_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = par_q;

`ifdef LOGIC_UNIT_STAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // saturating count of output handshakes
  always_comb begin
    cnt_d = cnt_q;
    if (s2_vld_q && out_ready && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign op_cnt = cnt_q;
`else
  assign op_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
// Build with or without LOGIC_UNIT_STAT_CNT_EN.
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       p;
  } exp_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] a = 0;
  logic [7:0] b = 0;
  logic [2:0] op = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [7:0] y;
  logic       zero;
  logic       parity;
  logic [3:0] op_cnt;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [3:0] cnt_m = 0;
  logic prev_stall = 0;
  logic [7:0] prev_y = 0;
  logic rand_rdy = 0;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic [2:0] mop);
    exp_t e;
    logic [7:0] r;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ~(ma & mb);
      3'd3: r = ~ma;
      3'd4: r = ~(ma | mb);
      3'd5: r = ma ^ mb;
      3'd6: r = ~(ma ^ mb);
      default: r = ma;
    endcase
    e.y = r;
    e.z = (r == 8'h00);
    e.p = ^r;
    return e;
  endfunction

  // monitor: handshakes are stable from negedge until the next posedge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_y", 64'(y), 64'(prev_y));
        check("stall_v", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("y", 64'(y), 64'(e.y));
          check("zero", 64'(zero), 64'(e.z));
          check("parity", 64'(parity), 64'(e.p));
          check("op_cnt", 64'(op_cnt), 64'(cnt_m));
`ifdef LOGIC_UNIT_STAT_CNT_EN
          if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, op));
      prev_stall = out_valid && !out_ready;
      prev_y = y;
    end
  end

  // random downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [7:0] ta, input logic [7:0] tb,
                      input logic [2:0] top);
    int n;
    in_valid = 1;
    a = ta;
    b = tb;
    op = top;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  initial begin
    int n;
    logic [7:0] yhold;
    rst_n = 0;
    #12;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_par", 64'(parity), 64'd0);
    check("rst_cnt", 64'(op_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // single op, latency 2
    send(8'hF0, 8'h3C, 3'b000);
    check("lat1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat2", 64'(out_valid), 64'd1);
    check("y_f0_3c", 64'(y), 64'h30);
    repeat (2) @(posedge clk);
    #1;

    // back-to-back all ops
    for (int i = 0; i < 8; i++) send(8'hAA, 8'h55, 3'(i));
    repeat (3) @(posedge clk);
    #1;

    // backpressure: two accepted then in_ready low
    out_ready = 0;
    send(8'h12, 8'h34, 3'b101);
    send(8'h0F, 8'hFF, 3'b000);
    in_valid = 1;
    a = 8'hC3;
    b = 8'h00;
    op = 3'b111;
    yhold = y;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_y", 64'(y), 64'(yhold));
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(negedge clk);
    check("rel_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;

    // reset with two ops in flight
    out_ready = 0;
    send(8'h01, 8'h02, 3'b001);
    send(8'h03, 8'h04, 3'b001);
    #3;
    rst_n = 0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);
    check("mrst_cnt", 64'(op_cnt), 64'd0);
    sb.delete();
    cnt_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_valid", 64'(out_valid), 64'd0);
    end

    // random traffic with random stalls
    rand_rdy = 1;
    for (int i = 0; i < 30; i++)
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    rand_rdy = 0;
    #1;
    out_ready = 1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
`ifdef LOGIC_UNIT_STAT_CNT_EN
    check("cnt_sat", 64'(op_cnt), 64'd15);
`else
    check("cnt_off", 64'(op_cnt), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
